vc_input_buffer: RTL and testbench

//  Per-input-port virtual-channel buffer that sits directly upstream of the VC arbiter.
//  - Steers each incoming word into one of two VC FIFOs (VC0/VC1) using the word's VC tag bit.
//  - Presents both FIFO heads first-word-fall-through, with empty/full/almost flags.
//  - The arbiter pops words with pop_vc0/pop_vc1; one instance is built per input port (p0, p1).

---
 rtl/vc_input_buffer.sv | 125 ++++++++++++
 tb/tb_vc_input_buffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vc_input_buffer.sv
// vc_input_buffer: per-input-port virtual-channel buffer feeding the VC arbiter.
// Incoming words are steered by their VC tag bit into one of two independent
// circular FIFOs. Each FIFO head is presented first-word-fall-through along with
// occupancy-derived status flags.
//
// Handshake: a word is offered when push=1 at a rising edge. It is accepted if its
// VC FIFO has room, or if that FIFO is full and is popped in the same cycle;
// otherwise it is dropped and overflow_err latches. pop_vcX=1 at a rising edge
// consumes the current data_vcX head when the FIFO is non-empty; a pop on an empty
// FIFO is ignored and latches underflow_err. Both pops may be asserted together.
// There is no ready signal. The source must honour pause, which asserts as soon as
// either VC reaches the almost-full threshold.
module vc_input_buffer #(
  parameter int DATA_WIDTH   = 5,
  parameter int DEPTH        = 8,
  parameter int ALMOST_FULL  = 6,
  parameter int ALMOST_EMPTY = 1
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     push,
  input  logic [DATA_WIDTH:0]      data_in,
  input  logic                     pop_vc0,
  input  logic                     pop_vc1,
  output logic [DATA_WIDTH-1:0]    data_vc0,
  output logic [DATA_WIDTH-1:0]    data_vc1,
  output logic                     empty_vc0,
  output logic                     empty_vc1,
  output logic                     full_vc0,
  output logic                     full_vc1,
  output logic                     almost_full_vc0,
  output logic                     almost_full_vc1,
  output logic                     almost_empty_vc0,
  output logic                     almost_empty_vc1,
  output logic                     pause,
  output logic [$clog2(DEPTH):0]   count_vc0,
  output logic [$clog2(DEPTH):0]   count_vc1,
  output logic                     overflow_err,
  output logic                     underflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Per-VC views exported from the generate loop.
  logic [CW-1:0]         countArr [2];
  logic [DATA_WIDTH-1:0] headArr  [2];
  logic                  ovfHit   [2];
  logic                  udfHit   [2];

  for (genvar v = 0; v < 2; v++) begin : gVc
    logic [PW-1:0]         wrPtr;
    logic [PW-1:0]         rdPtr;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  pushHit;
    logic                  popReq;
    logic                  isEmpty;
    logic                  isFull;
    logic                  popOk;
    logic                  pushOk;

    assign pushHit = push && (data_in[DATA_WIDTH] == 1'(v));
    assign popReq  = (v == 0) ? pop_vc0 : pop_vc1;
    assign isEmpty = (count == '0);
    assign isFull  = (count == CW'(DEPTH));
    // A full FIFO that is popped in the same cycle frees the slot the push needs.
    assign popOk   = popReq && !isEmpty;
    assign pushOk  = pushHit && (!isFull || popOk);

    assign ovfHit[v]   = pushHit && isFull && !popReq;
    assign udfHit[v]   = popReq && isEmpty;
    assign countArr[v] = count;
    assign headArr[v]  = isEmpty ? '0 : mem[rdPtr];

    // Payload storage; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
      if (pushOk) mem[wrPtr] <= data_in[DATA_WIDTH-1:0];
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
        wrPtr <= '0;
        rdPtr <= '0;
        count <= '0;
      end else begin
        if (pushOk) wrPtr <= wrPtr + PW'(1);
        if (popOk)  rdPtr <= rdPtr + PW'(1);
        unique case ({pushOk, popOk})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (ovfHit[0] || ovfHit[1]) overflow_err  <= 1'b1;
      if (udfHit[0] || udfHit[1]) underflow_err <= 1'b1;
    end
  end

  // Status outputs are pure functions of the registered counts.
  assign count_vc0        = countArr[0];
  assign count_vc1        = countArr[1];
  assign data_vc0         = headArr[0];
  assign data_vc1         = headArr[1];
  assign empty_vc0        = (countArr[0] == '0);
  assign empty_vc1        = (countArr[1] == '0);
  assign full_vc0         = (countArr[0] == CW'(DEPTH));
  assign full_vc1         = (countArr[1] == CW'(DEPTH));
  assign almost_full_vc0  = (countArr[0] >= CW'(ALMOST_FULL));
  assign almost_full_vc1  = (countArr[1] >= CW'(ALMOST_FULL));
  assign almost_empty_vc0 = (countArr[0] <= CW'(ALMOST_EMPTY));
  assign almost_empty_vc1 = (countArr[1] <= CW'(ALMOST_EMPTY));
  assign pause            = almost_full_vc0 || almost_full_vc1;

endmodule

// File: tb/tb_vc_input_buffer.sv
// Bench for vc_input_buffer: directed scenarios with known answers, followed by
// randomized traffic checked against a queue-based reference model.
module tb_vc_input_buffer;

  localparam int DW    = 5;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;
  localparam int CW    = 4;

  // Clock and reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_L;

  logic          push;
  logic [DW:0]   data_in;
  logic          pop_vc0, pop_vc1;
  logic [DW-1:0] data_vc0, data_vc1;
  logic          empty_vc0, empty_vc1, full_vc0, full_vc1;
  logic          almost_full_vc0, almost_full_vc1, almost_empty_vc0, almost_empty_vc1;
  logic          pause;
  logic [CW-1:0] count_vc0, count_vc1;
  logic          overflow_err, underflow_err;

  vc_input_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)) dut (
    .clk(clk), .reset_L(reset_L), .push(push), .data_in(data_in),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1), .data_vc0(data_vc0), .data_vc1(data_vc1),
    .empty_vc0(empty_vc0), .empty_vc1(empty_vc1), .full_vc0(full_vc0), .full_vc1(full_vc1),
    .almost_full_vc0(almost_full_vc0), .almost_full_vc1(almost_full_vc1),
    .almost_empty_vc0(almost_empty_vc0), .almost_empty_vc1(almost_empty_vc1),
    .pause(pause), .count_vc0(count_vc0), .count_vc1(count_vc1),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: one queue per VC plus the sticky error bits.
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic          exp_ovf;
  logic          exp_udf;

  function automatic void model_clear();
    exp_q0.delete();
    exp_q1.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
  endfunction

  // One clock cycle of the model. Pops take effect before the push so that a full
  // queue that is popped can still take the word.
  function automatic void model_step(input logic p, input logic [DW:0] d, input logic p0, input logic p1);
    if (p0) begin
      if (exp_q0.size() == 0) exp_udf = 1'b1;
      else void'(exp_q0.pop_front());
    end
    if (p1) begin
      if (exp_q1.size() == 0) exp_udf = 1'b1;
      else void'(exp_q1.pop_front());
    end
    if (p) begin
      if (d[DW] == 1'b0) begin
        if (exp_q0.size() < DEPTH) exp_q0.push_back(d[DW-1:0]);
        else exp_ovf = 1'b1;
      end else begin
        if (exp_q1.size() < DEPTH) exp_q1.push_back(d[DW-1:0]);
        else exp_ovf = 1'b1;
      end
    end
  endfunction

  // Driver tasks.
  task automatic do_reset();
    push = 1'b0; data_in = '0; pop_vc0 = 1'b0; pop_vc1 = 1'b0;
    reset_L = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    model_clear();
  endtask

  // Drive one cycle of inputs, clock it in, and return 1 ns after the edge.
  task automatic step(input logic p, input logic [DW:0] d, input logic p0, input logic p1);
    push = p; data_in = d; pop_vc0 = p0; pop_vc1 = p1;
    model_step(p, d, p0, p1);
    @(posedge clk);
    #1;
    push = 1'b0; data_in = '0; pop_vc0 = 1'b0; pop_vc1 = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (empty_vc0 !== 1'b1 || empty_vc1 !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b%b want 11", empty_vc0, empty_vc1); end
    n_cmp++; if (count_vc0 !== 4'd0 || count_vc1 !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d/%0d want 0/0", count_vc0, count_vc1); end
    n_cmp++; if ({full_vc0, full_vc1, almost_full_vc0, almost_full_vc1, pause} !== 5'b0) begin n_fail++; $display("FAIL reset_full_flags got %b want 00000", {full_vc0, full_vc1, almost_full_vc0, almost_full_vc1, pause}); end
    n_cmp++; if ({almost_empty_vc0, almost_empty_vc1} !== 2'b11) begin n_fail++; $display("FAIL reset_almost_empty got %b want 11", {almost_empty_vc0, almost_empty_vc1}); end
    n_cmp++; if (data_vc0 !== 5'h0 || data_vc1 !== 5'h0) begin n_fail++; $display("FAIL reset_data got %h/%h want 00/00", data_vc0, data_vc1); end
    n_cmp++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_errs got %b%b want 00", overflow_err, underflow_err); end
  endtask

  task automatic test_steering();
    do_reset();
    step(1'b1, {1'b0, 5'h13}, 1'b0, 1'b0);
    step(1'b1, {1'b1, 5'h0A}, 1'b0, 1'b0);
    n_cmp++; if (data_vc0 !== 5'h13) begin n_fail++; $display("FAIL steer_data_vc0 got %h want 13", data_vc0); end
    n_cmp++; if (data_vc1 !== 5'h0A) begin n_fail++; $display("FAIL steer_data_vc1 got %h want 0a", data_vc1); end
    n_cmp++; if (count_vc0 !== 4'd1 || count_vc1 !== 4'd1) begin n_fail++; $display("FAIL steer_counts got %0d/%0d want 1/1", count_vc0, count_vc1); end
    n_cmp++; if (empty_vc0 !== 1'b0 || empty_vc1 !== 1'b0) begin n_fail++; $display("FAIL steer_empty got %b%b want 00", empty_vc0, empty_vc1); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, {1'b0, 5'(i)}, 1'b0, 1'b0);
    n_cmp++; if (full_vc0 !== 1'b1 || count_vc0 !== 4'd8) begin n_fail++; $display("FAIL fill_full got full=%b cnt=%0d want 1/8", full_vc0, count_vc0); end
    n_cmp++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL fill_no_ovf got %b want 0", overflow_err); end
    step(1'b1, {1'b0, 5'h1F}, 1'b0, 1'b0);
    n_cmp++; if (overflow_err !== 1'b1 || count_vc0 !== 4'd8) begin n_fail++; $display("FAIL fill_ovf got ovf=%b cnt=%0d want 1/8", overflow_err, count_vc0); end
    n_cmp++; if (count_vc1 !== 4'd0) begin n_fail++; $display("FAIL fill_vc1_untouched got %0d want 0", count_vc1); end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++; if (data_vc0 !== 5'(i)) begin n_fail++; $display("FAIL drain_order[%0d] got %h want %h", i, data_vc0, 5'(i)); end
      step(1'b0, '0, 1'b1, 1'b0);
    end
    n_cmp++; if (empty_vc0 !== 1'b1 || data_vc0 !== 5'h0 || underflow_err !== 1'b0) begin n_fail++; $display("FAIL drain_end got e=%b d=%h u=%b want 1/00/0", empty_vc0, data_vc0, underflow_err); end
  endtask

  task automatic test_full_push_pop();
    logic [DW-1:0] ref_q[$];
    logic [DW-1:0] w;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      w = 5'($urandom);
      ref_q.push_back(w);
      step(1'b1, {1'b1, w}, 1'b0, 1'b0);
    end
    for (int i = 0; i < 13; i++) begin
      w = 5'($urandom);
      n_cmp++; if (data_vc1 !== ref_q[0]) begin n_fail++; $display("FAIL wrap_head[%0d] got %h want %h", i, data_vc1, ref_q[0]); end
      void'(ref_q.pop_front());
      ref_q.push_back(w);
      step(1'b1, {1'b1, w}, 1'b0, 1'b1);
      n_cmp++; if (count_vc1 !== 4'd8 || overflow_err !== 1'b0) begin n_fail++; $display("FAIL wrap_count[%0d] got cnt=%0d ovf=%b want 8/0", i, count_vc1, overflow_err); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++; if (data_vc1 !== ref_q[i]) begin n_fail++; $display("FAIL wrap_drain[%0d] got %h want %h", i, data_vc1, ref_q[i]); end
      step(1'b0, '0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_underflow_push();
    do_reset();
    step(1'b1, {1'b0, 5'h05}, 1'b1, 1'b0);
    n_cmp++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL udf_flag got %b want 1", underflow_err); end
    n_cmp++; if (count_vc0 !== 4'd1 || data_vc0 !== 5'h05) begin n_fail++; $display("FAIL udf_push got cnt=%0d d=%h want 1/05", count_vc0, data_vc0); end
    n_cmp++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL udf_no_ovf got %b want 0", overflow_err); end
  endtask

  task automatic test_almost_flags();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, {1'b0, 5'(i + 3)}, 1'b0, 1'b0);
      n_cmp++; if (almost_empty_vc0 !== (i <= 1)) begin n_fail++; $display("FAIL almost_empty@%0d got %b want %b", i, almost_empty_vc0, (i <= 1)); end
      n_cmp++; if (almost_full_vc0 !== (i >= 6) || pause !== (i >= 6)) begin n_fail++; $display("FAIL almost_full@%0d got af=%b pause=%b", i, almost_full_vc0, pause); end
    end
    step(1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (almost_full_vc0 !== 1'b0 || pause !== 1'b0 || count_vc0 !== 4'd5) begin n_fail++; $display("FAIL almost_full_release got af=%b pause=%b cnt=%0d want 0/0/5", almost_full_vc0, pause, count_vc0); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, {1'b0, 5'(5'h10 + 5'(i))}, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, {1'b1, 5'(i)}, 1'b0, 1'b0);
    n_cmp++; if (overflow_err !== 1'b1 || underflow_err !== 1'b1 || count_vc0 !== 4'd3) begin n_fail++; $display("FAIL areset_setup got ovf=%b udf=%b cnt=%0d want 1/1/3", overflow_err, underflow_err, count_vc0); end
    #2;
    reset_L = 1'b0;
    #1;
    n_cmp++; if (empty_vc0 !== 1'b1 || count_vc0 !== 4'd0 || data_vc0 !== 5'h0) begin n_fail++; $display("FAIL areset_vc0 got e=%b cnt=%0d d=%h want 1/0/00", empty_vc0, count_vc0, data_vc0); end
    n_cmp++; if (count_vc1 !== 4'd0 || full_vc1 !== 1'b0 || pause !== 1'b0) begin n_fail++; $display("FAIL areset_vc1 got cnt=%0d full=%b pause=%b want 0/0/0", count_vc1, full_vc1, pause); end
    n_cmp++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin n_fail++; $display("FAIL areset_errs got %b%b want 00", overflow_err, underflow_err); end
    model_clear();
    @(negedge clk);
    reset_L = 1'b1;
    step(1'b1, {1'b0, 5'h11}, 1'b0, 1'b0);
    n_cmp++; if (count_vc0 !== 4'd1 || data_vc0 !== 5'h11) begin n_fail++; $display("FAIL areset_first_push got cnt=%0d d=%h want 1/11", count_vc0, data_vc0); end
  endtask

  task automatic test_random();
    int push_rate, pop_rate;
    logic p, p0, p1;
    logic [DW:0] d;
    logic [DW-1:0] e_d0, e_d1;
    logic [3:0] e_f0, e_f1;
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      push_rate = (ph % 2 == 0) ? 85 : 30;
      pop_rate  = (ph % 2 == 0) ? 25 : 70;
      for (int n = 0; n < 150; n++) begin
        p  = ($urandom_range(0, 99) < push_rate);
        d  = (DW + 1)'($urandom);
        p0 = ($urandom_range(0, 99) < pop_rate);
        p1 = ($urandom_range(0, 99) < pop_rate);
        step(p, d, p0, p1);
        e_d0 = (exp_q0.size() > 0) ? exp_q0[0] : '0;
        e_d1 = (exp_q1.size() > 0) ? exp_q1[0] : '0;
        e_f0 = {exp_q0.size() == 0, exp_q0.size() == DEPTH, exp_q0.size() >= AF, exp_q0.size() <= AE};
        e_f1 = {exp_q1.size() == 0, exp_q1.size() == DEPTH, exp_q1.size() >= AF, exp_q1.size() <= AE};
        n_cmp++; if (data_vc0 !== e_d0) begin n_fail++; $display("FAIL rnd_data_vc0 ph%0d n%0d got %h want %h", ph, n, data_vc0, e_d0); end
        n_cmp++; if (data_vc1 !== e_d1) begin n_fail++; $display("FAIL rnd_data_vc1 ph%0d n%0d got %h want %h", ph, n, data_vc1, e_d1); end
        n_cmp++; if (count_vc0 !== CW'(exp_q0.size()) || count_vc1 !== CW'(exp_q1.size())) begin n_fail++; $display("FAIL rnd_count ph%0d n%0d got %0d/%0d want %0d/%0d", ph, n, count_vc0, count_vc1, exp_q0.size(), exp_q1.size()); end
        n_cmp++; if ({empty_vc0, full_vc0, almost_full_vc0, almost_empty_vc0} !== e_f0) begin n_fail++; $display("FAIL rnd_flags_vc0 ph%0d n%0d got %b want %b", ph, n, {empty_vc0, full_vc0, almost_full_vc0, almost_empty_vc0}, e_f0); end
        n_cmp++; if ({empty_vc1, full_vc1, almost_full_vc1, almost_empty_vc1} !== e_f1) begin n_fail++; $display("FAIL rnd_flags_vc1 ph%0d n%0d got %b want %b", ph, n, {empty_vc1, full_vc1, almost_full_vc1, almost_empty_vc1}, e_f1); end
        n_cmp++; if (pause !== (e_f0[1] || e_f1[1])) begin n_fail++; $display("FAIL rnd_pause ph%0d n%0d got %b want %b", ph, n, pause, (e_f0[1] || e_f1[1])); end
        n_cmp++; if (overflow_err !== exp_ovf || underflow_err !== exp_udf) begin n_fail++; $display("FAIL rnd_errs ph%0d n%0d got %b%b want %b%b", ph, n, overflow_err, underflow_err, exp_ovf, exp_udf); end
      end
    end
  endtask

  initial begin
    push = 1'b0; data_in = '0; pop_vc0 = 1'b0; pop_vc1 = 1'b0; reset_L = 1'b0;
    model_clear();
    test_reset();
    test_steering();
    test_fill_overflow();
    test_full_push_pop();
    test_underflow_push();
    test_almost_flags();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
